cic_sample_buffer: RTL and testbench
====================================

CIC_SAMPLE_BUFFER -- requirements
Module: cic_sample_buffer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports and parameters as follows.
- Parameters (name, default, meaning):
  - DECIMATION_FACTOR, 256: CIC decimation ratio; power of two.
  - CLOCK_WIDTH, $clog2(DECIMATION_FACTOR): divider width.
  - NUMBITS, 3*CLOCK_WIDTH+1: input sample width.
  - OUT_WIDTH, 16: signed output width; legal range 2..NUMBITS-2.
  - FIFO_DEPTH, 4: buffer entries; power of two, at least 2.
- Ports (name, direction, width, meaning):
  - clk, in, 1: modulator-rate clock.
  - reset, in, 1: synchronous active-high reset.
  - in_data, in, NUMBITS: unsigned CIC3 output word.
  - in_valid, in, 1: one-clk strobe per decimated sample; in_data is valid while it is high.
  - out_data, out, OUT_WIDTH: signed, centred, scaled sample.
  - out_valid, out, 1: FIFO head is valid.
  - out_ready, in, 1: consumer accepts the head.
  - overrun, out, 1: sticky flag, set when a sample is dropped.
  - overrun_clr, in, 1: clears overrun.

Function
REQ-002 Stage 1 SHALL register the conversion of in_data on every clk with in_valid=1, and SHALL set s1_valid for exactly one cycle.
REQ-003 The conversion SHALL be c = in_data - 2^(NUMBITS-2), computed signed in NUMBITS+1 bits, with SHIFT = NUMBITS-1-OUT_WIDTH.
REQ-004 The conversion SHALL round half-up: r = (c + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift; for SHIFT=0 no rounding term is added.
REQ-005 r SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], including in_data values above 2^(NUMBITS-1).
REQ-006 A stage-1 result SHALL be written to the FIFO in the cycle s1_valid=1 if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
REQ-007 Latency SHALL be: in_valid in cycle N produces out_valid=1 in cycle N+2 when the FIFO was empty and not popped.
REQ-008 A pop SHALL occur when out_valid && out_ready; out_data SHALL hold stable while out_valid=1 && out_ready=0.
REQ-009 A simultaneous push and pop SHALL leave count unchanged, including at full and at count=1.
REQ-010 On a dropped sample (full, no pop) the FIFO contents SHALL be unchanged and overrun SHALL set on the next edge.
REQ-011 overrun_clr SHALL clear overrun; a drop in the same cycle SHALL take priority, leaving overrun=1.
REQ-012 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be in range 0..FIFO_DEPTH.
REQ-013 Back-to-back in_valid in consecutive cycles SHALL be accepted with no bubbles while space exists.

Reset
REQ-014 With reset=1 at a clk edge, the block SHALL set s1_valid=0, pointers=0, count=0, out_valid=0, out_data=0, and overrun=0.
REQ-015 Reset mid-operation SHALL discard all buffered samples; in_valid during reset SHALL be ignored.
REQ-016 The first sample SHALL be accepted in the first cycle after reset deasserts.

Configuration
REQ-017 When CIC_SAMPLE_BUFFER_STATS_EN is defined, the block SHALL add output port drop_count [7:0] and output port peak_abs [OUT_WIDTH-1:0].
- drop_count increments on each dropped sample, saturates at 255, and clears on overrun_clr or reset.
- peak_abs holds the maximum |r| pushed, with -2^(OUT_WIDTH-1) counted as 2^(OUT_WIDTH-1)-1, and clears likewise.
REQ-018 Without the macro, these ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-019 Package cic_pkg SHALL hold the default DECIMATION_FACTOR, OUT_WIDTH, and FIFO_DEPTH constants, plus a conversion function (centre/round/saturate) shared by RTL and bench.
REQ-020 The FIFO SHALL be a sub-module, cic_sync_fifo, parameterised by width and depth, with push, pop, full, empty, and count.

Verification
REQ-021 The bench SHALL cover the following directed scenarios (defaults NUMBITS=25, OUT_WIDTH=16, SHIFT=8):
- in_data=8388608, single strobe -> out_data=0x0000, out_valid at N+2.
- in_data=16777216 and 0 -> 0x7FFF (saturated) and 0x8000; in_data=8388736 -> 1; 8388735 -> 0.
- out_ready=0, five strobes -> first four buffered in order, overrun=1, fifth dropped; with STATS_EN, drop_count=1.
- FIFO full, in_valid and out_ready both high in the same cycle -> count stays 4, new sample at tail, no overrun.
- Reset asserted with 3 samples buffered -> next cycle out_valid=0, overrun=0; next sample appears alone.
- overrun_clr coincident with a drop -> overrun remains 1; overrun_clr alone -> overrun=0 next cycle.

Source files
------------

// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared constants and sample conversion for the CIC sample buffer
//
// Purpose: default sizing constants and the centre/round/saturate conversion
//          that maps an unsigned CIC3 word to a signed, scaled output sample.
// Ports:   none (package).
package cic_pkg;

  localparam int DEFAULT_DECIMATION_FACTOR = 256;
  localparam int DEFAULT_OUT_WIDTH         = 16;
  localparam int DEFAULT_FIFO_DEPTH        = 4;

  // Centre on 2^(numbits-2), round half-up at the shift point, then clamp
  // to the signed out_width range. Widths are elaboration constants at every
  // call site, so the variable shifts fold away.
  function automatic longint cic_convert(input longint raw, input int numbits,
                                         input int out_width);
    longint c;
    longint r;
    longint hi;
    longint lo;
    int     shift;
    shift = numbits - 1 - out_width;
    c     = raw - (longint'(1) << (numbits - 2));
    if (shift > 0) c = c + (longint'(1) << (shift - 1));
    r  = c >>> shift;
    hi = (longint'(1) << (out_width - 1)) - 1;
    lo = -hi - 1;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/cic_sample_buffer_if.sv
// rtl/cic_sample_buffer_if.sv - sample stream and status bundle for cic_sample_buffer
//
// Purpose: groups the producer strobe, consumer handshake and overrun status.
// Signals: in_data/in_valid (CIC word strobe), out_data/out_valid/out_ready
//          (FIFO head handshake), overrun/overrun_clr (sticky drop flag).
// Modports: master = environment side, slave = cic_sample_buffer side.
interface cic_sample_buffer_if
  import cic_pkg::*;
#(
  parameter int NUMBITS   = 3 * $clog2(DEFAULT_DECIMATION_FACTOR) + 1,
  parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
);
  logic [NUMBITS-1:0]   in_data;
  logic                 in_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overrun;
  logic                 overrun_clr;

  modport master (
    output in_data, in_valid, out_ready, overrun_clr,
    input  out_data, out_valid, overrun
  );

  modport slave (
    input  in_data, in_valid, out_ready, overrun_clr,
    output out_data, out_valid, overrun
  );
endinterface

// File: rtl/cic_sync_fifo.sv
// rtl/cic_sync_fifo.sv - single-clock FIFO holding converted samples
//
// Purpose: DEPTH-entry (power of two) FIFO with push/pop and occupancy count.
// Ports:   clk, reset (sync, active-high), push/wdata, pop/rdata,
//          full, empty, count (0..DEPTH).
module cic_sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A push into a full FIFO is only taken when the head leaves in the same
  // cycle; at full wr_ptr == rd_ptr, so the new word lands in the freed slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cic_sample_buffer.sv
// rtl/cic_sample_buffer.sv - CIC3 output converter with sample FIFO and overrun flag
//
// Purpose: converts each strobed CIC word to a signed OUT_WIDTH sample in one
//          register stage and queues it for a ready/valid consumer.
// Ports:   clk, reset (sync, active-high), bus (cic_sample_buffer_if.slave).
//          With CIC_SAMPLE_BUFFER_STATS_EN defined: drop_count[7:0] (saturating
//          drop counter) and peak_abs[OUT_WIDTH-1:0] (largest |sample| queued).
module cic_sample_buffer
  import cic_pkg::*;
#(
  parameter int DECIMATION_FACTOR = DEFAULT_DECIMATION_FACTOR,
  parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
  parameter int NUMBITS           = 3 * CLOCK_WIDTH + 1,
  parameter int OUT_WIDTH         = DEFAULT_OUT_WIDTH,
  parameter int FIFO_DEPTH        = DEFAULT_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  cic_sample_buffer_if.slave   bus
`ifdef CIC_SAMPLE_BUFFER_STATS_EN
  ,
  output logic [7:0]           drop_count,
  output logic [OUT_WIDTH-1:0] peak_abs
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 s1_valid;
  logic [OUT_WIDTH-1:0] s1_data;
  logic [OUT_WIDTH-1:0] conv;
  logic [OUT_WIDTH-1:0] head;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 drop;

  assign conv = OUT_WIDTH'(cic_convert(64'(bus.in_data), NUMBITS, OUT_WIDTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_data <= conv;
    end
  end

  assign pop  = bus.out_valid && bus.out_ready;
  assign drop = s1_valid && fifo_full && !pop;

  cic_sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s1_valid),
    .wdata (s1_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.out_valid = !fifo_empty;
  // Storage is not reset, so an empty FIFO presents zero instead of stale data.
  assign bus.out_data  = (fifo_count == '0) ? '0 : head;

  // A drop outranks a coincident clear so no lost sample goes unreported.
  always_ff @(posedge clk) begin
    if (reset)                bus.overrun <= 1'b0;
    else if (drop)            bus.overrun <= 1'b1;
    else if (bus.overrun_clr) bus.overrun <= 1'b0;
  end

`ifdef CIC_SAMPLE_BUFFER_STATS_EN
  localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [OUT_WIDTH-1:0] s1_abs;
  logic                 pushed;

  assign pushed = s1_valid && !drop;

  // The most negative code has no positive twin; report it as full scale.
  always_comb begin
    s1_abs = s1_data;
    if (s1_data == MIN_NEG)            s1_abs = MAX_POS;
    else if (s1_data[OUT_WIDTH-1])     s1_abs = -s1_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
      peak_abs   <= '0;
    end else if (bus.overrun_clr) begin
      drop_count <= drop ? 8'd1 : 8'd0;
      peak_abs   <= pushed ? s1_abs : '0;
    end else begin
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (pushed && s1_abs > peak_abs) peak_abs <= s1_abs;
    end
  end
`endif
endmodule

// File: tb/tb_cic_sample_buffer.sv
// tb/tb_cic_sample_buffer.sv - self-checking bench for cic_sample_buffer
module tb_cic_sample_buffer;
  localparam int NB    = 25;
  localparam int OW    = 16;
  localparam int SH    = NB - 1 - OW;
  localparam int DEPTH = 4;
  localparam int BASE  = 1 << (NB - 2);

  typedef struct {
    int in_data;
    int exp_out;
  } vec_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  cic_sample_buffer_if #(.NUMBITS(NB), .OUT_WIDTH(OW)) bus ();

`ifdef CIC_SAMPLE_BUFFER_STATS_EN
  logic [7:0]    drop_count;
  logic [OW-1:0] peak_abs;
  int            m_dc;
  int            m_pk;
`endif

  cic_sample_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CIC_SAMPLE_BUFFER_STATS_EN
    ,
    .drop_count (drop_count),
    .peak_abs   (peak_abs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: pending stage-1 sample, queued samples, flag.
  int q[$];
  bit pend;
  int pend_val;
  bit m_ovr;

  function automatic int ref_conv(longint d);
    longint x;
    longint div;
    longint r;
    longint hi;
    div = longint'(1) << SH;
    x   = d - BASE;
    if (SH > 0) x = x + div / 2;
    r = x / div;
    if (x < 0 && (x % div) != 0) r = r - 1;
    hi = (longint'(1) << (OW - 1)) - 1;
    if (r > hi) r = hi;
    if (r < -hi - 1) r = -hi - 1;
    return int'(r);
  endfunction

  function automatic int ref_abs(int v);
    if (v == -(1 << (OW - 1))) return (1 << (OW - 1)) - 1;
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name,
               $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Advance the model by one clock using the inputs now applied, clock the
  // DUT, then compare outputs 1 ns after the edge.
  task automatic cycle();
    bit pop;
    bit pushv;
    bit drop;
    if (reset) begin
      q.delete();
      pend  = 0;
      m_ovr = 0;
`ifdef CIC_SAMPLE_BUFFER_STATS_EN
      m_dc = 0;
      m_pk = 0;
`endif
    end else begin
      pop   = (q.size() > 0) && bus.out_ready;
      pushv = pend && (q.size() < DEPTH || pop);
      drop  = pend && !pushv;
      if (pop) void'(q.pop_front());
      if (pushv) q.push_back(pend_val);
      if (drop) m_ovr = 1;
      else if (bus.overrun_clr) m_ovr = 0;
`ifdef CIC_SAMPLE_BUFFER_STATS_EN
      if (bus.overrun_clr) begin
        m_dc = drop ? 1 : 0;
        m_pk = pushv ? ref_abs(pend_val) : 0;
      end else begin
        if (drop && m_dc < 255) m_dc++;
        if (pushv && ref_abs(pend_val) > m_pk) m_pk = ref_abs(pend_val);
      end
`endif
      pend     = bus.in_valid;
      pend_val = ref_conv(longint'(bus.in_data));
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) check("out_data", 32'($signed(bus.out_data)), q[0]);
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
`ifdef CIC_SAMPLE_BUFFER_STATS_EN
    check("drop_count", 32'(drop_count), m_dc);
    check("peak_abs", 32'(peak_abs), m_pk);
`endif
  endtask

  task automatic strobes(int first_k, int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = NB'(BASE + (first_k + i) * 256);
      cycle();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain_expect(int first_k, int n, string name);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check(name, 32'($signed(bus.out_data)), first_k + i);
      cycle();
    end
    bus.out_ready = 1'b0;
    check({name, "_empty"}, 32'(bus.out_valid), 0);
  endtask

  vec_t vecs[8];

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{8388608, 0};
    vecs[1] = '{16777216, 32767};
    vecs[2] = '{0, -32768};
    vecs[3] = '{8388736, 1};
    vecs[4] = '{8388735, 0};
    vecs[5] = '{33554431, 32767};
    vecs[6] = '{8388480, 0};
    vecs[7] = '{8388479, -1};

    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    bus.overrun_clr = 1'b0;
    cycle();
    cycle();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    reset = 1'b0;

    // Conversion table with N+2 latency check.
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = NB'(vecs[i].in_data);
      cycle();
      bus.in_valid = 1'b0;
      check("lat_n1_invalid", 32'(bus.out_valid), 0);
      cycle();
      check("lat_n2_valid", 32'(bus.out_valid), 1);
      check("conv_value", 32'($signed(bus.out_data)), vecs[i].exp_out);
      bus.out_ready = 1'b1;
      cycle();
      bus.out_ready = 1'b0;
    end

    // Five strobes into a stalled consumer: four kept in order, fifth dropped.
    strobes(1, 5);
    cycle();
    check("ovr_set", 32'(bus.overrun), 1);
`ifdef CIC_SAMPLE_BUFFER_STATS_EN
    check("ovr_drop_count", 32'(drop_count), 1);
`endif
    drain_expect(1, 4, "ovr_order");
    bus.overrun_clr = 1'b1;
    cycle();
    bus.overrun_clr = 1'b0;
    check("clr_alone", 32'(bus.overrun), 0);

    // Full FIFO with push and pop together: no drop, new sample at tail.
    strobes(1, 5);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    check("full_pushpop_no_ovr", 32'(bus.overrun), 0);
    drain_expect(2, 4, "full_pushpop_order");

    // Clear coincident with a drop keeps the flag; clear alone drops it.
    strobes(1, 5);
    bus.overrun_clr = 1'b1;
    cycle();
    bus.overrun_clr = 1'b0;
    check("clr_vs_drop", 32'(bus.overrun), 1);
    bus.overrun_clr = 1'b1;
    cycle();
    bus.overrun_clr = 1'b0;
    check("clr_after_drop", 32'(bus.overrun), 0);
    drain_expect(1, 4, "clr_drain");

    // Reset with three samples queued and overrun set; in_valid during reset
    // is ignored and the first post-reset strobe is taken.
    strobes(1, 5);
    cycle();
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = NB'(BASE + 9 * 256);
    cycle();
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_overrun", 32'(bus.overrun), 0);
    check("mid_rst_out_data", 32'(bus.out_data), 0);
    reset       = 1'b0;
    bus.in_data = NB'(BASE + 7 * 256);
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    check("post_rst_valid", 32'(bus.out_valid), 1);
    check("post_rst_data", 32'($signed(bus.out_data)), 7);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    check("post_rst_alone", 32'(bus.out_valid), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid    = ($urandom_range(0, 2) != 0);
      bus.in_data     = NB'($urandom_range(0, (1 << NB) - 1));
      bus.out_ready   = ($urandom_range(0, 2) == 0);
      bus.overrun_clr = ($urandom_range(0, 15) == 0);
      reset           = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.overrun_clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
